// File: rtl/h264_dc_hadamard_xform_if.sv
// DC Hadamard transform stream interface.
// Sample input side plus result output side with valid/ready.
interface h264_dc_hadamard_xform_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = IN_W + 4
);
  logic                    MODE;
  logic                    ENABLE;
  logic signed [IN_W-1:0]  XXIN;
  logic                    READYI;
  logic                    VALID;
  logic signed [OUT_W-1:0] YYOUT;
  logic                    LAST;
  logic                    READYO;

  modport master (
    output MODE, ENABLE, XXIN, READYO,
    input  READYI, VALID, YYOUT, LAST
  );

  modport slave (
    input  MODE, ENABLE, XXIN, READYO,
    output READYI, VALID, YYOUT, LAST
  );
endinterface

// File: rtl/h264_dc_hadamard_xform.sv
// H.264 DC Hadamard transform: 2x2 chroma or 4x4 luma,
// load / compute in place / stream out with backpressure.
module h264_dc_hadamard_xform #(
  parameter int IN_W    = 16,
  parameter int OUT_W   = IN_W + 4,
  parameter bit LUMA_EN = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  h264_dc_hadamard_xform_if.slave io
);
  localparam int W = IN_W + 4;

  if (OUT_W < IN_W + 3) begin : g_width_chk
    $error("OUT_W must be at least IN_W+3");
  end

  typedef enum logic [1:0] {
    LOAD,
    CALC,
    EMIT
  } state_t;

  state_t              state;
  logic signed [W-1:0] bf [16];
  logic [3:0]          cnt;
  logic [3:0]          ocnt;
  logic [2:0]          step;
  logic                mode_q;

  logic signed [W-1:0] o [4];
  logic signed [W-1:0] s [4];
  logic [1:0]          idx;
  logic                m_in;
  logic                m_eff;
  logic [3:0]          n_last;
  logic [3:0]          onext;

  function automatic logic signed [OUT_W-1:0] to_out(
    input logic signed [W-1:0] v
  );
    return OUT_W'(v);
  endfunction

  assign m_in   = io.MODE && LUMA_EN;
  assign m_eff  = (cnt == 4'd0) ? m_in : mode_q;
  assign n_last = mode_q ? 4'd15 : 4'd3;
  assign onext  = ocnt + 4'd1;

  assign io.READYI = RESET && (state == LOAD);

  // step[2]=0 selects a row of the buffer, step[2]=1 a column
  always_comb begin
    idx = step[1:0];
    for (int k = 0; k < 4; k++) begin
      o[k] = step[2] ? bf[{2'(k), idx}]
                     : bf[{idx, 2'(k)}];
    end
    s[0] = o[0] + o[1] + o[2] + o[3];
    s[1] = o[0] + o[1] - o[2] - o[3];
    s[2] = o[0] - o[1] - o[2] + o[3];
    s[3] = o[0] - o[1] + o[2] - o[3];
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= LOAD;
      cnt      <= '0;
      ocnt     <= '0;
      step     <= '0;
      mode_q   <= 1'b0;
      io.VALID <= 1'b0;
      io.LAST  <= 1'b0;
      io.YYOUT <= '0;
      for (int i = 0; i < 16; i++) begin
        bf[i] <= '0;
      end
    end else begin
      unique case (1'b1)
        state == LOAD: begin
          if (io.ENABLE) begin
            bf[cnt] <= W'(io.XXIN);
            cnt     <= cnt + 4'd1;
            if (cnt == 4'd0) mode_q <= m_in;
            if (cnt == (m_eff ? 4'd15 : 4'd3)) begin
              state <= CALC;
              cnt   <= '0;
              step  <= '0;
            end
          end
        end
        state == CALC: begin
          if (!mode_q) begin
            // 2x2 operands are bf[0..3]; outputs in raster order
            bf[0]    <= s[0];
            bf[1]    <= s[3];
            bf[2]    <= s[1];
            bf[3]    <= s[2];
            state    <= EMIT;
            ocnt     <= '0;
            io.VALID <= 1'b1;
            io.LAST  <= 1'b0;
            io.YYOUT <= to_out(s[0]);
          end else begin
            for (int j = 0; j < 4; j++) begin
              if (!step[2]) begin
                bf[{idx, 2'(j)}] <= s[j];
              end else begin
                bf[{2'(j), idx}] <= s[j] >>> 1;
              end
            end
            step <= step + 3'd1;
            // bf[0] was finalised by the first column pass
            if (step == 3'd7) begin
              state    <= EMIT;
              ocnt     <= '0;
              io.VALID <= 1'b1;
              io.LAST  <= 1'b0;
              io.YYOUT <= to_out(bf[0]);
            end
          end
        end
        state == EMIT: begin
          if (io.READYO) begin
            if (ocnt == n_last) begin
              state    <= LOAD;
              ocnt     <= '0;
              io.VALID <= 1'b0;
              io.LAST  <= 1'b0;
            end else begin
              ocnt     <= onext;
              io.YYOUT <= to_out(bf[onext]);
              io.LAST  <= (onext == n_last);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_h264_dc_hadamard_xform.sv
// Directed bench for h264_dc_hadamard_xform.
// Hand-computed vectors for 2x2, 4x4, backpressure and reset.
module tb_h264_dc_hadamard_xform;
  logic CLK = 1'b0;
  logic RESET;
  int   tests = 0;
  int   fails = 0;

  logic signed [19:0] got [16];
  logic               glast [16];
  logic               gval [16];
  int                 lat;
  int                 e [16];

  h264_dc_hadamard_xform_if #(.IN_W(16), .OUT_W(20)) io ();

  h264_dc_hadamard_xform #(
    .IN_W(16), .OUT_W(20), .LUMA_EN(1'b1)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .io(io)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input int v);
    io.ENABLE = 1'b1;
    io.XXIN   = 16'(v);
    tick();
    io.ENABLE = 1'b0;
  endtask

  task automatic wait_valid();
    lat = 0;
    while (!io.VALID && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic collect(input int n);
    wait_valid();
    for (int i = 0; i < n; i++) begin
      got[i]   = io.YYOUT;
      glast[i] = io.LAST;
      gval[i]  = io.VALID;
      tick();
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    #2;
    tests++;
    if (io.VALID !== 1'b0 || io.LAST !== 1'b0) begin
      fails++;
      $display("FAIL rst_flags: valid=%b last=%b want 0 0",
               io.VALID, io.LAST);
    end
    tests++;
    if (io.YYOUT !== 20'sd0) begin
      fails++;
      $display("FAIL rst_yy: got %0d want 0", io.YYOUT);
    end
    tests++;
    if (io.READYI !== 1'b0) begin
      fails++;
      $display("FAIL rst_readyi: got %b want 0", io.READYI);
    end
    tick();
    RESET = 1'b1;
    tick();
    tests++;
    if (io.READYI !== 1'b1) begin
      fails++;
      $display("FAIL rst_release_readyi: got %b want 1", io.READYI);
    end
  endtask

  task automatic test_2x2();
    io.MODE = 1'b0;
    send(1); send(2); send(3); send(4);
    collect(4);
    e[0:3] = '{10, -2, -4, 0};
    tests++;
    if (lat != 1) begin
      fails++;
      $display("FAIL t1_latency: got %0d edges want 1", lat);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (gval[i] !== 1'b1 || got[i] !== 20'(e[i])) begin
        fails++;
        $display("FAIL t1_y[%0d]: got %0d (v=%b) want %0d",
                 i, got[i], gval[i], e[i]);
      end
      tests++;
      if (glast[i] !== (i == 3)) begin
        fails++;
        $display("FAIL t1_last[%0d]: got %b want %b",
                 i, glast[i], i == 3);
      end
    end
    tests++;
    if (io.VALID !== 1'b0 || io.READYI !== 1'b1) begin
      fails++;
      $display("FAIL t1_done: valid=%b readyi=%b want 0 1",
               io.VALID, io.READYI);
    end
  endtask

  task automatic test_2x2_gap();
    io.MODE = 1'b0;
    send(1); send(2);
    tick();
    send(3); send(4);
    collect(4);
    e[0:3] = '{10, -2, -4, 0};
    tests++;
    if (lat != 1) begin
      fails++;
      $display("FAIL t2_latency: got %0d want 1", lat);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got[i] !== 20'(e[i]) || glast[i] !== (i == 3)) begin
        fails++;
        $display("FAIL t2_y[%0d]: got %0d last=%b want %0d",
                 i, got[i], glast[i], e[i]);
      end
    end
  endtask

  task automatic test_4x4_ramp();
    io.MODE = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(i % 4);
      io.MODE = 1'b0;
    end
    collect(16);
    e = '{12, -8, 0, -4, 0, 0, 0, 0,
          0, 0, 0, 0, 0, 0, 0, 0};
    tests++;
    if (lat != 8) begin
      fails++;
      $display("FAIL t3_latency: got %0d want 8", lat);
    end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (gval[i] !== 1'b1 || got[i] !== 20'(e[i]) ||
          glast[i] !== (i == 15)) begin
        fails++;
        $display("FAIL t3_y[%0d]: got %0d v=%b last=%b want %0d",
                 i, got[i], gval[i], glast[i], e[i]);
      end
    end
  endtask

  task automatic test_4x4_extreme();
    io.MODE = 1'b1;
    for (int i = 0; i < 16; i++) send(-32768);
    collect(16);
    for (int i = 0; i < 16; i++) begin
      e[i] = (i == 0) ? -262144 : 0;
      tests++;
      if (got[i] !== 20'(e[i])) begin
        fails++;
        $display("FAIL t4_y[%0d]: got %0d want %0d",
                 i, got[i], e[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    io.MODE   = 1'b0;
    io.READYO = 1'b1;
    send(1); send(2); send(3); send(4);
    wait_valid();
    tests++;
    if (io.YYOUT !== 20'sd10) begin
      fails++;
      $display("FAIL t5_first: got %0d want 10", io.YYOUT);
    end
    tick();
    io.READYO = 1'b0;
    io.ENABLE = 1'b1;
    io.XXIN   = 16'sd99;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if (io.VALID !== 1'b1 || io.YYOUT !== -20'sd2 ||
          io.LAST !== 1'b0 || io.READYI !== 1'b0) begin
        fails++;
        $display("FAIL t5_hold[%0d]: v=%b y=%0d l=%b ri=%b want 1 -2 0 0",
                 c, io.VALID, io.YYOUT, io.LAST, io.READYI);
      end
    end
    io.ENABLE = 1'b0;
    io.READYO = 1'b1;
    tick();
    tests++;
    if (io.YYOUT !== -20'sd4 || io.LAST !== 1'b0) begin
      fails++;
      $display("FAIL t5_y2: got %0d last=%b want -4 0",
               io.YYOUT, io.LAST);
    end
    tick();
    tests++;
    if (io.YYOUT !== 20'sd0 || io.LAST !== 1'b1) begin
      fails++;
      $display("FAIL t5_y3: got %0d last=%b want 0 1",
               io.YYOUT, io.LAST);
    end
    tick();
    tests++;
    if (io.VALID !== 1'b0) begin
      fails++;
      $display("FAIL t5_end: valid=%b want 0", io.VALID);
    end
    send(1); send(1); send(1); send(1);
    collect(4);
    e[0:3] = '{4, 0, 0, 0};
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got[i] !== 20'(e[i])) begin
        fails++;
        $display("FAIL t5_next[%0d]: got %0d want %0d",
                 i, got[i], e[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int vcnt;
    io.MODE = 1'b1;
    for (int i = 0; i < 16; i++) send(i % 4);
    tick();
    tick();
    RESET = 1'b0;
    #1;
    tests++;
    if (io.VALID !== 1'b0 || io.READYI !== 1'b0) begin
      fails++;
      $display("FAIL t6_rst: valid=%b readyi=%b want 0 0",
               io.VALID, io.READYI);
    end
    tick();
    RESET = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (io.VALID === 1'b1) vcnt++;
    end
    tests++;
    if (vcnt != 0 || io.READYI !== 1'b1) begin
      fails++;
      $display("FAIL t6_discard: valid cycles=%0d readyi=%b want 0 1",
               vcnt, io.READYI);
    end
    io.MODE = 1'b0;
    send(9); send(9);
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    send(5); send(6); send(7); send(8);
    collect(4);
    e[0:3] = '{26, -2, -4, 0};
    tests++;
    if (lat != 1) begin
      fails++;
      $display("FAIL t6_latency: got %0d want 1", lat);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got[i] !== 20'(e[i]) || glast[i] !== (i == 3)) begin
        fails++;
        $display("FAIL t6_y[%0d]: got %0d last=%b want %0d",
                 i, got[i], glast[i], e[i]);
      end
    end
  endtask

  task automatic test_reset_emit();
    io.MODE   = 1'b0;
    io.READYO = 1'b0;
    send(1); send(2); send(3); send(4);
    wait_valid();
    tests++;
    if (io.VALID !== 1'b1) begin
      fails++;
      $display("FAIL t7_valid: got %b want 1", io.VALID);
    end
    #2;
    RESET = 1'b0;
    #1;
    tests++;
    if (io.VALID !== 1'b0 || io.YYOUT !== 20'sd0 ||
        io.LAST !== 1'b0) begin
      fails++;
      $display("FAIL t7_async: v=%b y=%0d l=%b want 0 0 0",
               io.VALID, io.YYOUT, io.LAST);
    end
    tick();
    RESET     = 1'b1;
    io.READYO = 1'b1;
    tick();
  endtask

  initial begin
    io.MODE   = 1'b0;
    io.ENABLE = 1'b0;
    io.XXIN   = '0;
    io.READYO = 1'b1;
    RESET     = 1'b1;
    #1;
    test_reset();
    test_2x2();
    test_2x2_gap();
    test_4x4_ramp();
    test_4x4_extreme();
    test_backpressure();
    test_reset_mid();
    test_reset_emit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
